fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the program memory. Owns the architectural fetch PC and drives it to the combinational byte-addressed program memory. Captures the returned 32-bit instruction word together with its PC in a small prefetch FIFO. Presents entries to decode over a valid/ready handshake and supports branch/jump redirect with flush.

---
 rtl/fetch_unit.sv | 80 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads the combinational program memory,
// and queues {pc, instruction} pairs in a small prefetch FIFO toward decode.
module fetch_unit #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 501
) (
  input  logic        clk,
  input  logic        nReset,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instrOut,
  output logic [31:0] instrPc,
  output logic        fetchFault
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C   = DEPTH[AW:0];
  localparam logic [32:0] MEM_LIMIT = MEM_BYTES[32:0];

  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          in_range;
  logic          push;
  logic          pop;

  // 33-bit sum so a PC near 2^32 cannot wrap back into the valid range
  assign in_range = (({1'b0, pc} + 33'd3) < MEM_LIMIT);

  assign instrValid = (count != '0);
  assign pop        = instrValid & instrReady & ~redirect;
  assign push       = ~redirect & in_range & ((count < DEPTH_C) | pop);

  assign instrOut = instrValid ? fifo_instr[rd_ptr] : 32'h0;
  assign instrPc  = instrValid ? fifo_pc[rd_ptr]    : 32'h0;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      pc         <= RESET_PC;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fetchFault <= 1'b0;
    end else if (redirect) begin
      pc         <= {redirectTarget[31:2], 2'b00};
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fetchFault <= 1'b0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (!in_range) begin
        fetchFault <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= instruction;
      fifo_pc[wr_ptr]    <= pc;
    end
  end

endmodule
